// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module   : divider
// Brief    : Sequential unsigned restoring divider, one quotient bit per clock,
//            with a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [1:0]       c_IDLE = 2'd0;
    localparam logic [1:0]       c_CALC = 2'd1;
    localparam logic [1:0]       c_DONE = 2'd2;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_y;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;

    assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_last   = (r_state == c_CALC) && (r_cnt == c_LAST);

    // The shifted partial remainder is below 2*Y, so in a WIDTH+1 bit
    // difference the top bit is set exactly when the subtraction borrowed.
    assign w_shift    = {r_rem, r_q[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_y};
    assign w_fits     = ~w_trial[WIDTH];
    assign w_rem_next = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_q_next   = {r_q[WIDTH-2:0], w_fits};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (start) begin
                    w_next_state = (Y == '0) ? c_DONE : c_CALC;
                end else begin
                    w_next_state = c_IDLE;
                end
            end
            c_CALC: begin
                if (r_cnt == c_LAST) begin
                    w_next_state = c_DONE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_CALC:  busy = 1'b1;
            c_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem       <= '0;
            r_q         <= '0;
            r_y         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            if (Y == '0) begin
                r_quotient  <= '1;
                r_remainder <= X;
                r_dbz       <= 1'b1;
            end else begin
                r_y   <= Y;
                r_rem <= '0;
                r_q   <= X;
                r_cnt <= '0;
            end
        end else if (r_state == c_CALC) begin
            r_rem <= w_rem_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_quotient  <= w_q_next;
                r_remainder <= w_rem_next;
                r_dbz       <= 1'b0;
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider
// Brief    : Self-checking bench for divider: vector table, corner sequences,
//            and a randomized sweep against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int errors = 0;
    int checks = 0;
    int double_done = 0;
    logic prev_done = 1'b0;

    divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .X           (X),
        .Y           (Y),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prev_done && done && !rst) double_done <= double_done + 1;
        prev_done <= done;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
        if (y == 0) begin
            q = 32'hFFFF_FFFF; r = x; dz = 1'b1;
        end else begin
            q = x / y; r = x % y; dz = 1'b0;
        end
    endfunction

    // Waits for done; lat counts edges after the accepting edge.
    task automatic wait_done(input int already, output int lat, output int busy_cnt);
        lat = already;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_cnt++;
            if (lat > 100) begin
                checks++; errors++;
                $display("FAIL timeout: done not seen after %0d edges, required 32", lat);
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic run_div(input logic [31:0] x, input logic [31:0] y,
                           output int lat, output int busy_cnt);
        @(negedge clk);
        X = x; Y = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(0, lat, busy_cnt);
    endtask

    initial begin
        int lat, bcnt;
        logic [31:0] eq, er;
        logic        edz;
        logic [31:0] x, y;
        logic [63:0] prod;

        vecs[0] = '{x: 32'd100,        y: 32'd7,          q: 32'd14,         r: 32'd2,    dz: 1'b0};
        vecs[1] = '{x: 32'hFFFF_FFFF,  y: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,    dz: 1'b0};
        vecs[2] = '{x: 32'd5,          y: 32'd9,          q: 32'd0,          r: 32'd5,    dz: 1'b0};
        vecs[3] = '{x: 32'd1234,       y: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd1234, dz: 1'b1};
        vecs[4] = '{x: 32'd0,          y: 32'd5,          q: 32'd0,          r: 32'd0,    dz: 1'b0};
        vecs[5] = '{x: 32'd7,          y: 32'd7,          q: 32'd1,          r: 32'd0,    dz: 1'b0};
        vecs[6] = '{x: 32'hFFFF_FFFF,  y: 32'hFFFF_FFFE,  q: 32'd1,          r: 32'd1,    dz: 1'b0};
        vecs[7] = '{x: 32'h8000_0000,  y: 32'd3,          q: 32'h2AAA_AAAA,  r: 32'd2,    dz: 1'b0};

        rst = 1'b1; start = 1'b1; X = 32'd5; Y = 32'd3;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", div_by_zero, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle_after_reset_busy", busy, 0);

        for (int i = 0; i < 8; i++) begin
            run_div(vecs[i].x, vecs[i].y, lat, bcnt);
            check($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
            check($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
            check($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].dz);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].dz ? 0 : WIDTH);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].dz ? 0 : WIDTH);
            check($sformatf("vec%0d_busy_in_done", i), busy, 0);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), done, 0);
        end

        // A start during CALC must be ignored.
        @(negedge clk);
        X = 32'd1000; Y = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        X = 32'd8; Y = 32'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(10, lat, bcnt);
        check("ignored_start_quotient", quotient, 333);
        check("ignored_start_remainder", remainder, 1);
        check("ignored_start_latency", lat, WIDTH);
        @(negedge clk);

        // Back-to-back: start held during the DONE cycle.
        run_div(32'd100, 32'd7, lat, bcnt);
        check("b2b_first_quotient", quotient, 14);
        check("b2b_first_remainder", remainder, 2);
        X = 32'd50; Y = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_outputs_hold", quotient, 14);
        wait_done(0, lat, bcnt);
        check("b2b_second_quotient", quotient, 10);
        check("b2b_second_remainder", remainder, 0);
        check("b2b_second_latency", lat, WIDTH);
        @(negedge clk);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        X = 32'd77; Y = 32'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_quotient", quotient, 0);
        check("midreset_remainder", remainder, 0);
        check("midreset_dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        run_div(32'd77, 32'd4, lat, bcnt);
        check("after_reset_quotient", quotient, 19);
        check("after_reset_remainder", remainder, 1);
        check("after_reset_latency", lat, WIDTH);
        @(negedge clk);

        // Sweep: X counting from 0 with Y stepping every 25 ops, then random.
        for (int i = 0; i < 160; i++) begin
            if (i < 100) begin
                x = 32'(i);
                y = 32'(1 + i / 25);
            end else begin
                x = $urandom;
                y = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            end
            model(x, y, eq, er, edz);
            run_div(x, y, lat, bcnt);
            check($sformatf("sweep%0d_q x=%0h y=%0h", i, x, y), quotient, eq);
            check($sformatf("sweep%0d_r x=%0h y=%0h", i, x, y), remainder, er);
            check($sformatf("sweep%0d_dbz", i), div_by_zero, edz);
            check($sformatf("sweep%0d_latency", i), lat, edz ? 0 : WIDTH);
            if (y != 0) begin
                prod = 64'(quotient) * 64'(y) + 64'(remainder);
                check($sformatf("sweep%0d_identity", i), prod, 64'(x));
                check($sformatf("sweep%0d_rem_lt_y", i), remainder < y, 1);
            end
            @(negedge clk);
        end

        check("no_double_done", double_done, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
